// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: one 16-bit ripple adder
// time-shared over WORDS limbs, LSB first, carry held in a register.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, sampled only while busy=0
//   sub             0: a+b+cin, 1: a-b (cin ignored)
//   a, b, cin       operands, sampled with start
//   busy            high while limbs are being processed
//   done            one-cycle completion pulse
//   sum             registered W-bit result
//   cout            carry out of MSB limb (sub: 1 = no borrow)
//   overflow        signed overflow of the full W-bit operation

module RippleCarryAdder16Bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 16; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) |
                  (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[16];
  end

endmodule

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                overflow
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_c;

  logic [15:0]   w_la;
  logic [15:0]   w_lb;
  logic [15:0]   w_s;
  logic          w_co;
  logic [W-1:0]  w_full;
  logic          w_last;

  assign w_la   = r_a[r_idx*16 +: 16];
  assign w_lb   = r_b[r_idx*16 +: 16];
  assign w_last = (r_idx == IW'(WORDS - 1));

  RippleCarryAdder16Bit u_add (
    .i_a    (w_la),
    .i_b    (w_lb),
    .i_cin  (r_c),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  // Result with the limb currently on the adder merged in, so the
  // final limb is visible in the same cycle it completes.
  always_comb begin
    w_full = r_res;
    w_full[r_idx*16 +: 16] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_c      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub | cin;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res <= w_full;
          r_c   <= w_co;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            sum      <= w_full;
            cout     <= w_co;
            // Signed overflow: operands agree in sign, result does not.
            overflow <= (r_a[W-1] == r_b[W-1]) &&
                        (w_full[W-1] != r_a[W-1]);
            done     <= 1'b1;
            busy     <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=4 main DUT,
// WORDS=1 secondary DUT for the single-limb case).

module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, sub, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, overflow;

  logic         start1, sub1, cin1;
  logic [15:0]  a1, b1, sum1;
  logic         busy1, done1, cout1, ovf1;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
    .cout(cout), .overflow(overflow)
  );

  multiword_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1),
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .overflow(ovf1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [W+1:0] got,
                     input logic [W+1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(
    input logic [W-1:0] fa, input logic [W-1:0] fb,
    input logic fc, input logic fs);
    logic [W-1:0] bp;
    logic [W:0]   r;
    logic         ov;
    bp = fs ? ~fb : fb;
    r  = {1'b0, fa} + {1'b0, bp} + {{W{1'b0}}, (fs | fc)};
    ov = (fa[W-1] == bp[W-1]) && (r[W-1] != fa[W-1]);
    return {r[W-1:0], r[W], ov};
  endfunction

  logic [W+1:0] q[$];
  logic [W+1:0] held = '0;
  int  busyrun  = 0;
  int  cyc      = 0;
  int  last_acc = -1;
  bit  hold_mode = 1'b0;

  always @(posedge clk) begin
    logic p_rst;
    logic p_acc;
    logic [W+1:0] e;
    p_rst = rst;
    p_acc = start && !busy;
    cyc++;
    if (!hold_mode) last_acc = -1;
    if (!p_rst && p_acc) begin
      q.push_back(model(a, b, cin, sub));
      if (hold_mode && last_acc >= 0)
        chk("accept_spacing", (W+2)'(cyc - last_acc), (W+2)'(5));
      last_acc = cyc;
    end
    #1;
    if (p_rst) begin
      q.delete();
      held = '0;
    end
    if (done) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", {sum, cout, overflow}, e);
        held = e;
      end
      chk("busy_cycles", (W+2)'(busyrun), (W+2)'(WORDS));
    end else begin
      chk("hold", {sum, cout, overflow}, held);
    end
    busyrun = busy ? busyrun + 1 : 0;
  end

  task automatic do_op(input string tag,
                       input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo);
    bit seen;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_sum"}, (W+2)'(sum), (W+2)'(es));
      chk({tag, "_cout"}, (W+2)'(cout), (W+2)'(ec));
      chk({tag, "_ovf"}, (W+2)'(overflow), (W+2)'(eo));
      chk({tag, "_busy_lo"}, (W+2)'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1;
    a = 64'h1111; b = 64'h2222;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0;
    a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", (W+2)'(busy), 0);
    chk("rst_done", (W+2)'(done), 0);
    chk("rst_out", {sum, cout, overflow}, 0);
    rst = 1'b0; start = 1'b0;

    do_op("limb_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
          64'h0, 1'b1, 1'b0);
    do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("sub_neg", 64'h5, 64'h7, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Start held high with fresh operands every cycle.
    @(negedge clk);
    hold_mode = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 22; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    hold_mode = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a RUN.
    a = 64'h1234; b = 64'h1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", (W+2)'(busy), 0);
    chk("abort_done", (W+2)'(done), 0);
    chk("abort_out", {sum, cout, overflow}, 0);
    repeat (6) @(negedge clk);
    do_op("after_abort", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);

    // Single-limb instance.
    @(negedge clk);
    a1 = 16'hFFFF; b1 = 16'h0001; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", (W+2)'(busy1), 1);
    chk("w1_done_early", (W+2)'(done1), 0);
    @(negedge clk);
    chk("w1_done", (W+2)'(done1), 1);
    chk("w1_out", (W+2)'({sum1, cout1, ovf1}), (W+2)'({16'h0, 1'b1, 1'b0}));
    chk("w1_busy_lo", (W+2)'(busy1), 0);
    @(negedge clk);
    chk("w1_done_pulse", (W+2)'(done1), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", (W+2)'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-precision add/subtract controller that time-shares one RippleCarryAdder16Bit over WORDS 16-bit limbs, LSB limb first.
- The carry is registered between limbs.
- Used wherever the design needs 32/64-bit arithmetic without instantiating wider adders.
- Start/busy/done handshake to the requesting block. Results are held stable until the next completion.

Parameters:
- WORDS, 4, number of 16-bit limbs per operand (legal 1..16). Operand width W = 16*WORDS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, carry-in forced 1, cin ignored).
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- cin  input  1  carry-in for add, sampled with start.
- busy  output  1  high while limbs are being processed.
- done  output  1  one-cycle completion pulse.
- sum  output  W  registered result.
- cout  output  1  carry out of MSB limb; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow of the full W-bit operation.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, state=IDLE, limb index=0, carry register=0. Reset wins over any start in the same cycle. Reset mid-RUN aborts the operation: no done pulse, and sum/cout/overflow are cleared.
- States: IDLE, RUN.
- IDLE:
  - On an edge with start=1: latch a, b (b inverted if sub), sub, and carry = sub ? 1 : cin. Set index=0, busy=1, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each cycle, drive the adder with limb[index] of latched a/b and the carry register.
  - At the edge: write the adder sum into the internal result limb[index] and the adder cout into the carry register; index++.
  - When index = WORDS-1 at the edge:
    - Copy the full result to sum, set cout = adder cout, set overflow.
    - Set done=1, busy=0, go to IDLE.
- Overflow: overflow = (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]), where b' is the latched, possibly inverted, B.
- Latency: start sampled at edge E0; busy high during the WORDS cycles after E0; done and the new sum are valid in the cycle after edge E0+WORDS.
- done is high for exactly one cycle. It deasserts on the next edge unless that edge completes another operation.
- Back-to-back operation: in the cycle done=1 the state is IDLE, so a start there is accepted (throughput = one op per WORDS+1 cycles minimum... exactly WORDS cycles of RUN plus one IDLE sample cycle).
- start while busy=1 is ignored entirely: no queuing, and operand changes have no effect.
- a, b, cin and sub are don't-care except on the start edge.
- sum/cout/overflow hold their last completed values through IDLE and through the next RUN. They change only at completion or reset.
- WORDS=1: RUN lasts one cycle; done asserts in the cycle after E0+1.
- Exactly one RippleCarryAdder16Bit instance; no other adder in the datapath. The index counter is $clog2(WORDS) bits wide, minimum 1.

Test Plan (WORDS=4 unless noted):
- Reset check: assert rst 2 cycles with start=1 → busy=0, done=0, sum=0, cout=0, overflow=0. No operation starts.
- Limb carry: a=0x0000_0000_0000_FFFF, b=0x1, cin=0, sub=0, start pulse → busy high exactly 4 cycles. done pulses 1 cycle after that with sum=0x0000_0000_0001_0000, cout=0, overflow=0.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, overflow=0. Second case: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=1 (must be ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Second case: a=0x8000_0000_0000_0000, b=1, sub=1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, overflow=1.
- Busy/back-to-back: hold start=1 continuously with new operands every cycle → only the operands present on each accepting edge are used. Accepting edges are spaced 5 cycles apart; each done carries the correct sum. Start during RUN changes nothing.
- Reset mid-op: start 0x1234+0x1, assert rst after 2 RUN cycles → no done, outputs 0. Then start 3+4 → sum=7 after normal latency. Repeat the limb-carry case with WORDS=1: 0xFFFF+1 → sum=0, cout=1, done one cycle after RUN.
